// File: rtl/vme_cycle_seq.sv
// vme_cycle_seq: VME slave cycle sequencer.
// Accepts a qualified data strobe, grants the lowest-index selected device,
// pulses its start line, waits for its completion (or a timeout), then
// acknowledges the VME master on DTACK_B, returning readback data on OUTDATA
// for read cycles. Timed-out cycles still acknowledge, with a marker word.
//
// Ports
//   FASTCLK  in   single clock, rising edge
//   RST      in   synchronous reset, active-high
//   STROBE   in   qualified data strobe, active-high
//   WRITE_B  in   1 = read, 0 = write
//   DEVICE   in   [3:0]  decoded device selects
//   COMMAND  in   [9:0]  VME command field
//   DEV_ACK  in   [3:0]  per-device completion
//   DEV_DATA in   [63:0] readback, device k on [16k+15:16k]
//   DEV_GO   out  [3:0]  one-cycle start pulse to granted device
//   CMD_OUT  out  [9:0]  COMMAND latched at cycle start
//   RW_OUT   out         WRITE_B latched at cycle start
//   OUTDATA  out  [15:0] tristate readback bus
//   DTACK_B  out         tristate acknowledge, driven 0 or z
//   TMO_CNT  out  [7:0]  saturating count of timed-out cycles
//
// state | meaning
// IDLE  | no cycle in progress, waiting for strobe with a device selected
// GO    | start pulse on DEV_GO[grant]
// WAIT  | waiting for DEV_ACK[grant], counting toward TIMEOUT
// ACK   | device completed, DTACK asserted until strobe falls
// ERR   | device timed out, DTACK asserted with marker data until strobe falls
module vme_cycle_seq #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        FASTCLK,
    input  logic        RST,
    input  logic        STROBE,
    input  logic        WRITE_B,
    input  logic [3:0]  DEVICE,
    input  logic [9:0]  COMMAND,
    input  logic [3:0]  DEV_ACK,
    input  logic [63:0] DEV_DATA,
    output logic [3:0]  DEV_GO,
    output logic [9:0]  CMD_OUT,
    output logic        RW_OUT,
    output logic [15:0] OUTDATA,
    output logic        DTACK_B,
    output logic [7:0]  TMO_CNT
);

    typedef enum logic [2:0] {IDLE, GO, WAIT, ACK, ERR} state_t;

    state_t      state;
    logic [1:0]  grant;
    logic [7:0]  cyc_cnt;
    logic [15:0] rd_reg;
    logic        drive;

    function automatic logic [1:0] low_idx(input logic [3:0] sel);
        if (sel[0])      return 2'd0;
        else if (sel[1]) return 2'd1;
        else if (sel[2]) return 2'd2;
        else             return 2'd3;
    endfunction

    always_ff @(posedge FASTCLK) begin
        if (RST) begin
            state   <= IDLE;
            grant   <= 2'd0;
            cyc_cnt <= 8'd0;
            rd_reg  <= 16'd0;
            DEV_GO  <= 4'd0;
            CMD_OUT <= 10'd0;
            RW_OUT  <= 1'b0;
            TMO_CNT <= 8'd0;
        end else begin
            DEV_GO <= 4'd0;
            case (state)
                IDLE: begin
                    if (STROBE && (DEVICE != 4'd0)) begin
                        CMD_OUT <= COMMAND;
                        RW_OUT  <= WRITE_B;
                        grant   <= low_idx(DEVICE);
                        DEV_GO  <= 4'd1 << low_idx(DEVICE);
                        state   <= GO;
                    end
                end
                GO: begin
                    cyc_cnt <= 8'd0;
                    state   <= STROBE ? WAIT : IDLE;
                end
                WAIT: begin
                    // Abort beats ack, and ack beats timeout.
                    if (!STROBE) begin
                        state <= IDLE;
                    end else if (DEV_ACK[grant]) begin
                        rd_reg <= DEV_DATA[{grant, 4'd0} +: 16];
                        state  <= ACK;
                    end else if (cyc_cnt == TIMEOUT) begin
                        if (TMO_CNT != 8'hFF)
                            TMO_CNT <= TMO_CNT + 8'd1;
                        state <= ERR;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                ACK, ERR: begin
                    if (!STROBE)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus drivers follow the registered state directly, so they release on
    // the first IDLE cycle after the strobe falls or after reset.
    assign drive   = (state == ACK) || (state == ERR);
    assign DTACK_B = drive ? 1'b0 : 1'bz;
    assign OUTDATA = (drive && RW_OUT) ? ((state == ERR) ? 16'hDEAD : rd_reg)
                                       : 16'hzzzz;

endmodule

// File: tb/tb_vme_cycle_seq.sv
// Bench for vme_cycle_seq. The VME-style open-drain lines are pulled up, so a
// released DTACK_B reads 1 and a released OUTDATA reads 16'hFFFF.
module tb_vme_cycle_seq;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        strobe;
    logic        write_b;
    logic [3:0]  device;
    logic [9:0]  command;
    logic [3:0]  dev_ack;
    logic [63:0] dev_data;
    wire  [3:0]  dev_go;
    wire  [9:0]  cmd_out;
    wire         rw_out;
    wire  [15:0] outdata;
    wire         dtack_b;
    wire  [7:0]  tmo_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_tmo  = 0;

    vme_cycle_seq #(.TIMEOUT(8'd4)) dut (
        .FASTCLK  (clk),
        .RST      (rst),
        .STROBE   (strobe),
        .WRITE_B  (write_b),
        .DEVICE   (device),
        .COMMAND  (command),
        .DEV_ACK  (dev_ack),
        .DEV_DATA (dev_data),
        .DEV_GO   (dev_go),
        .CMD_OUT  (cmd_out),
        .RW_OUT   (rw_out),
        .OUTDATA  (outdata),
        .DTACK_B  (dtack_b),
        .TMO_CNT  (tmo_cnt)
    );

    pullup (dtack_b);
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (outdata[i]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete VME access. ack_at: WAIT-cycle index at which the granted
    // device acks (-1 = never). abort_edge: edge (counted from the start
    // edge = 1) at which STROBE is already low (0 = no abort).
    task automatic run_cycle(input logic [3:0] dev, input logic wb,
                             input logic [9:0] cmd, input logic [15:0] data,
                             input int ack_at, input int abort_edge,
                             input logic [3:0] noise);
        int          g;
        int          end_edge;
        int          hold;
        logic        timed_out;
        logic        bad_dtack;
        logic        bad_go;
        logic [15:0] exp_out;
        g = 0;
        for (int i = 3; i >= 0; i--) if (dev[i]) g = i;
        dev_data = {$urandom, $urandom};
        dev_data[g*16 +: 16] = data;
        device  = dev;
        write_b = wb;
        command = cmd;
        dev_ack = noise & ~(4'd1 << g);
        strobe  = 1'b1;
        bad_dtack = 1'b0;
        bad_go    = 1'b0;

        if (abort_edge != 0) begin
            for (int e = 1; e <= abort_edge; e++) begin
                if (e == abort_edge) strobe = 1'b0;
                tick();
                if (e == 1) chk("abort_go", {12'd0, dev_go}, 16'd1 << g);
                else if (dev_go !== 4'd0) bad_go = 1'b1;
                if (dtack_b !== 1'b1) bad_dtack = 1'b1;
            end
            for (int k = 0; k < 3; k++) begin
                tick();
                if (dtack_b !== 1'b1) bad_dtack = 1'b1;
                if (dev_go !== 4'd0) bad_go = 1'b1;
            end
            chk("abort_no_dtack", {15'd0, bad_dtack}, 16'd0);
            chk("abort_no_go", {15'd0, bad_go}, 16'd0);
            chk("abort_tmo", {8'd0, tmo_cnt}, exp_tmo[15:0]);
            chk("abort_bus", outdata, 16'hFFFF);
            return;
        end

        timed_out = !(ack_at >= 0 && ack_at <= TMO);
        end_edge  = timed_out ? 3 + TMO : 3 + ack_at;
        if (timed_out && exp_tmo < 255) exp_tmo++;
        exp_out = !wb ? 16'hFFFF : (timed_out ? 16'hDEAD : data);

        for (int e = 1; e <= end_edge; e++) begin
            if (!timed_out && e == 3 + ack_at) dev_ack[g] = 1'b1;
            tick();
            dev_ack[g] = 1'b0;
            if (e == 1) begin
                chk("go_pulse", {12'd0, dev_go}, 16'd1 << g);
                chk("cmd_out", {6'd0, cmd_out}, {6'd0, cmd});
                chk("rw_out", {15'd0, rw_out}, {15'd0, wb});
            end else if (dev_go !== 4'd0) begin
                bad_go = 1'b1;
            end
            if (e < end_edge && dtack_b !== 1'b1) bad_dtack = 1'b1;
        end
        chk("early_dtack", {15'd0, bad_dtack}, 16'd0);
        chk("single_go", {15'd0, bad_go}, 16'd0);
        chk(timed_out ? "err_dtack" : "ack_dtack", {15'd0, dtack_b}, 16'd0);
        chk(timed_out ? "err_data" : "ack_data", outdata, exp_out);
        chk("tmo_cnt", {8'd0, tmo_cnt}, exp_tmo[15:0]);

        hold = $urandom_range(0, 3);
        bad_dtack = 1'b0;
        for (int k = 0; k < hold; k++) begin
            dev_ack = 4'($urandom);
            tick();
            if (dtack_b !== 1'b0 || outdata !== exp_out) bad_dtack = 1'b1;
        end
        chk("hold", {15'd0, bad_dtack}, 16'd0);
        strobe  = 1'b0;
        dev_ack = 4'd0;
        tick();
        chk("release_dtack", {15'd0, dtack_b}, 16'd1);
        chk("release_data", outdata, 16'hFFFF);
    endtask

    initial begin
        logic bad;
        rst      = 1'b1;
        strobe   = 1'b0;
        write_b  = 1'b1;
        device   = 4'd0;
        command  = 10'd0;
        dev_ack  = 4'd0;
        dev_data = 64'd0;
        tick();
        tick();
        chk("rst_go", {12'd0, dev_go}, 16'd0);
        chk("rst_cmd", {6'd0, cmd_out}, 16'd0);
        chk("rst_rw", {15'd0, rw_out}, 16'd0);
        chk("rst_dtack", {15'd0, dtack_b}, 16'd1);
        chk("rst_data", outdata, 16'hFFFF);
        chk("rst_tmo", {8'd0, tmo_cnt}, 16'd0);
        rst = 1'b0;

        // Strobe with no device selected does nothing.
        strobe  = 1'b1;
        command = 10'h3FF;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (dev_go !== 4'd0 || dtack_b !== 1'b1 || cmd_out !== 10'd0) bad = 1'b1;
        end
        chk("idle_nodev", {15'd0, bad}, 16'd0);
        strobe = 1'b0;
        tick();

        run_cycle(4'b0100, 1'b1, 10'h005, 16'h7E1A, 2, 0, 4'd0);
        run_cycle(4'b1010, 1'b1, 10'h123, 16'h1357, 1, 0, 4'b1000);
        run_cycle(4'b1010, 1'b1, 10'h0AA, 16'h2468, -1, 0, 4'b1000);
        run_cycle(4'b0001, 1'b0, 10'h2C3, 16'h5A5A, 0, 0, 4'd0);
        run_cycle(4'b1000, 1'b1, 10'h011, 16'h4321, -1, 0, 4'd0);
        run_cycle(4'b0010, 1'b1, 10'h0F0, 16'hBEEF, TMO, 0, 4'd0);
        run_cycle(4'b0100, 1'b1, 10'h001, 16'h1111, -1, 4, 4'd0);
        run_cycle(4'b1000, 1'b1, 10'h002, 16'h2222, -1, 2, 4'd0);

        for (int t = 0; t < 40; t++) begin
            int r;
            int ack_at;
            int ab;
            r = $urandom_range(0, 9);
            ack_at = -1;
            ab = 0;
            if (r < 6)      ack_at = $urandom_range(0, TMO);
            else if (r > 7) ab = $urandom_range(2, 3 + TMO);
            run_cycle(4'($urandom_range(1, 15)), 1'($urandom), 10'($urandom),
                      16'($urandom_range(0, 16'hFFFE)), ack_at, ab, 4'($urandom));
        end

        for (int t = 0; t < 256; t++)
            run_cycle(4'($urandom_range(1, 15)), 1'b1, 10'($urandom),
                      16'h0000, -1, 0, 4'd0);
        chk("tmo_saturated", {8'd0, tmo_cnt}, 16'h00FF);

        // Reset while in ACK.
        device  = 4'b0001;
        write_b = 1'b1;
        dev_ack = 4'b0001;
        strobe  = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_rst_ack", {15'd0, dtack_b}, 16'd0);
        rst     = 1'b1;
        strobe  = 1'b0;
        dev_ack = 4'd0;
        tick();
        chk("mid_rst_dtack", {15'd0, dtack_b}, 16'd1);
        chk("mid_rst_data", outdata, 16'hFFFF);
        chk("mid_rst_tmo", {8'd0, tmo_cnt}, 16'd0);
        chk("mid_rst_cmd", {6'd0, cmd_out}, 16'd0);
        rst = 1'b0;
        exp_tmo = 0;
        tick();
        run_cycle(4'b0110, 1'b1, 10'h155, 16'hC0DE, 1, 0, 4'd0);
        run_cycle(4'b0001, 1'b1, 10'h066, 16'h0000, -1, 0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
